// File: rtl/pipe_test_pkg.sv
// Shared types and constants for the Pipe Out test-data generator.
// Mode encoding, FSM state codes, LFSR taps, seed layout and throttle reset value.
package pipe_test_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_LFSR    = 2'd1,
    MODE_WALK    = 2'd2,
    MODE_PATTERN = 2'd3
  } mode_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int LFSR_TAP_A = 31;
  localparam int LFSR_TAP_B = 21;
  localparam int LFSR_TAP_C = 1;

  localparam int SEED_BYTE_BASE   = 1;
  localparam int SEED_BYTE_STRIDE = 9;

  localparam logic [31:0] THROTTLE_RESET = 32'hFFFF_FFFF;

  // Lane k LFSR seed holds bytes b+3..b (MSB..LSB), b = base + stride*k.
  function automatic logic [31:0] lfsr_seed(input int lane);
    logic [7:0] b;
    b = 8'(SEED_BYTE_BASE + SEED_BYTE_STRIDE * lane);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] r);
    return {r[30:0], r[LFSR_TAP_A] ^ r[LFSR_TAP_B] ^ r[LFSR_TAP_C]};
  endfunction

endpackage

// File: rtl/pipe_out_lane.sv
// One 32-bit generator lane: loads its per-lane seed on start and steps once per
// write in the mode latched at load time.
module pipe_out_lane
  import pipe_test_pkg::*;
#(
  parameter int LANE_IDX = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [1:0]  mode,
  input  logic [31:0] pattern,
  output logic [31:0] value
);

  logic [1:0]  mode_q;
  logic [31:0] seed;
  logic [31:0] next_val;

  always_comb begin
    seed = 32'd1;
    case (mode)
      MODE_COUNT: seed = 32'd1;
      MODE_LFSR:  seed = lfsr_seed(LANE_IDX);
      MODE_WALK:  seed = 32'd1 << LANE_IDX;
      default:    seed = pattern;
    endcase
  end

  always_comb begin
    next_val = value;
    case (mode_q)
      MODE_COUNT: next_val = value + 32'd1;
      MODE_LFSR:  next_val = lfsr_next(value);
      MODE_WALK:  next_val = {value[30:0], value[31]};
      default:    next_val = value;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value  <= 32'd0;
      mode_q <= MODE_COUNT;
    end else if (load) begin
      value  <= seed;
      mode_q <= mode;
    end else if (step) begin
      value  <= next_val;
    end
  end

endmodule

// File: rtl/pipe_out_gen.sv
// Pipe Out test-data source: LANES x 32-bit lanes, throttle/FIFO gated, counted runs.
// Optional build macro PIPE_OUT_GEN_ERRINJ_EN adds single-bit error injection on lane 0.
module pipe_out_gen
  import pipe_test_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int COUNT_W    = 9,
  parameter int FIFO_LIMIT = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [31:0]           xfer_len,
  input  logic [31:0]           pattern,
  input  logic                  throttle_set,
  input  logic [31:0]           throttle_val,
  input  logic [COUNT_W-1:0]    pipe_out_count,
`ifdef PIPE_OUT_GEN_ERRINJ_EN
  input  logic                  errinj_arm,
  input  logic [31:0]           errinj_idx,
`endif
  output logic                  pipe_out_write,
  output logic [32*LANES-1:0]   pipe_out_data,
  output logic                  busy,
  output logic                  done
);

  logic [1:0]            state;
  logic [31:0]           throttle;
  logic [31:0]           words_left;
  logic                  unlimited;
  logic                  start_ok;
  logic                  fifo_ok;
  logic                  issue;
  logic                  last;
  logic [32*LANES-1:0]   lane_data;

  assign start_ok = start && !abort && (state == ST_IDLE);
  assign fifo_ok  = 32'(pipe_out_count) < 32'(FIFO_LIMIT);
  assign issue    = (state == ST_RUN) && !abort && fifo_ok && throttle[0];
  assign last     = issue && !unlimited && (words_left == 32'd1);
  assign busy     = (state == ST_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      words_left <= 32'd0;
      unlimited  <= 1'b0;
    end else if (abort) begin
      state      <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state      <= ST_RUN;
          words_left <= xfer_len;
          unlimited  <= (xfer_len == 32'd0);
        end
        ST_RUN: if (issue) begin
          if (!unlimited) words_left <= words_left - 32'd1;
          if (last) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Throttle keeps rotating in every state so its phase is independent of runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      throttle       <= THROTTLE_RESET;
      pipe_out_write <= 1'b0;
      done           <= 1'b0;
    end else begin
      throttle       <= throttle_set ? throttle_val : {throttle[0], throttle[31:1]};
      pipe_out_write <= issue;
      done           <= (state == ST_DONE) && !abort;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pipe_out_lane #(.LANE_IDX(k)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load    (start_ok),
      .step    (pipe_out_write),
      .mode    (mode),
      .pattern (pattern),
      .value   (lane_data[32*k +: 32])
    );
  end

`ifdef PIPE_OUT_GEN_ERRINJ_EN
  logic        armed;
  logic        inj_now;
  logic [31:0] wr_idx;
  logic [31:0] inj_idx;

  // Corruption is applied only on the bus; lane registers keep the true sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed   <= 1'b0;
      inj_now <= 1'b0;
      wr_idx  <= 32'd0;
      inj_idx <= 32'd0;
    end else begin
      inj_now <= 1'b0;
      if (start_ok) begin
        armed   <= errinj_arm;
        inj_idx <= errinj_idx;
        wr_idx  <= 32'd0;
      end else if (issue) begin
        wr_idx <= wr_idx + 32'd1;
        if (armed && (wr_idx == inj_idx)) begin
          inj_now <= 1'b1;
          armed   <= 1'b0;
        end
      end
    end
  end

  assign pipe_out_data = lane_data ^ {{(32*LANES-1){1'b0}}, inj_now};
`else
  assign pipe_out_data = lane_data;
`endif

endmodule

// File: tb/tb_pipe_out_gen.sv
// Directed self-checking bench for pipe_out_gen (LANES=2).
// Build with PIPE_OUT_GEN_ERRINJ_EN defined to also cover error injection.
module tb_pipe_out_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [31:0] xfer_len;
  logic [31:0] pattern;
  logic        throttle_set;
  logic [31:0] throttle_val;
  logic [8:0]  pipe_out_count;
  logic        pipe_out_write;
  logic [63:0] pipe_out_data;
  logic        busy;
  logic        done;
`ifdef PIPE_OUT_GEN_ERRINJ_EN
  logic        errinj_arm;
  logic [31:0] errinj_idx;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [63:0] wq[$];
  int          wt[$];
  int          done_cnt;
  int          cycle_no = 0;
  logic        busy_s;

  always #5 clk = ~clk;

  pipe_out_gen dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .mode           (mode),
    .xfer_len       (xfer_len),
    .pattern        (pattern),
    .throttle_set   (throttle_set),
    .throttle_val   (throttle_val),
    .pipe_out_count (pipe_out_count),
`ifdef PIPE_OUT_GEN_ERRINJ_EN
    .errinj_arm     (errinj_arm),
    .errinj_idx     (errinj_idx),
`endif
    .pipe_out_write (pipe_out_write),
    .pipe_out_data  (pipe_out_data),
    .busy           (busy),
    .done           (done)
  );

  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    return {r[30:0], r[31] ^ r[21] ^ r[1]};
  endfunction

  // Sample at the falling edge, then return just after the next rising edge.
  task automatic cyc();
    @(negedge clk);
    if (pipe_out_write) begin
      wq.push_back(pipe_out_data);
      wt.push_back(cycle_no);
    end
    if (done) done_cnt++;
    busy_s = busy;
    cycle_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq.delete();
    wt.delete();
    done_cnt = 0;
  endtask

  task automatic load_throttle(input logic [31:0] v);
    throttle_set = 1'b1;
    throttle_val = v;
    cyc();
    throttle_set = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [31:0] len, input logic [31:0] pat);
    mode     = m;
    xfer_len = len;
    pattern  = pat;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors += 5;
    if (pipe_out_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b want 0", pipe_out_write); end
    if (pipe_out_data !== 64'd0) begin errors++; $display("FAIL rst_data: got %h want 0", pipe_out_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    if (dut.throttle !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_throttle: got %h want ffffffff", dut.throttle); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lfsr();
    logic [31:0] l0, l1;
    load_throttle(32'hFFFF_FFFF);
    clear_log();
    pulse_start(2'd1, 32'd4, 32'd0);
    cyc();
    vectors++;
    if (busy_s !== 1'b1) begin errors++; $display("FAIL lfsr_busy: got %b want 1", busy_s); end
    repeat (12) cyc();
    vectors += 3;
    if (wq.size() != 4) begin errors++; $display("FAIL lfsr_count: got %0d want 4", wq.size()); end
    if (done_cnt != 1) begin errors++; $display("FAIL lfsr_done: got %0d want 1", done_cnt); end
    if (busy_s !== 1'b0) begin errors++; $display("FAIL lfsr_busy_end: got %b want 0", busy_s); end
    l0 = 32'h0403_0201;
    l1 = 32'h0D0C_0B0A;
    for (int i = 0; i < wq.size(); i++) begin
      vectors++;
      if (wq[i] !== {l1, l0}) begin errors++; $display("FAIL lfsr_w%0d: got %h want %h", i, wq[i], {l1, l0}); end
      l0 = lfsr_step(l0);
      l1 = lfsr_step(l1);
    end
  endtask

  task automatic test_walk();
    logic [63:0] exp_w[3];
    exp_w[0] = {32'h2, 32'h1};
    exp_w[1] = {32'h4, 32'h2};
    exp_w[2] = {32'h8, 32'h4};
    clear_log();
    pulse_start(2'd2, 32'd3, 32'd0);
    repeat (10) cyc();
    vectors++;
    if (wq.size() != 3) begin errors++; $display("FAIL walk_count: got %0d want 3", wq.size()); end
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      vectors++;
      if (wq[i] !== exp_w[i]) begin errors++; $display("FAIL walk_w%0d: got %h want %h", i, wq[i], exp_w[i]); end
    end
  endtask

  task automatic test_throttle();
    load_throttle(32'h0000_0001);
    clear_log();
    pulse_start(2'd0, 32'd0, 32'd0);
    repeat (100) cyc();
    vectors += 2;
    if (busy_s !== 1'b1) begin errors++; $display("FAIL thr_busy: got %b want 1", busy_s); end
    if (wq.size() < 3 || wq.size() > 4) begin
      errors++; $display("FAIL thr_count: got %0d want 3..4", wq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wq[i] !== {32'(i + 1), 32'(i + 1)}) begin
          errors++; $display("FAIL thr_w%0d: got %h want %h", i, wq[i], {32'(i + 1), 32'(i + 1)});
        end
      end
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (wt[i] - wt[i-1] != 32) begin errors++; $display("FAIL thr_gap%0d: got %0d want 32", i, wt[i] - wt[i-1]); end
      end
    end
    pulse_abort();
    repeat (2) cyc();
  endtask

  task automatic test_fifo_limit();
    int n;
    bit seq_ok;
    load_throttle(32'hFFFF_FFFF);
    clear_log();
    pipe_out_count = 9'd499;
    pulse_start(2'd0, 32'd0, 32'd0);
    repeat (8) cyc();
    vectors++;
    if (wq.size() != 7) begin errors++; $display("FAIL fifo_499: got %0d writes want 7", wq.size()); end
    n = wq.size();
    pipe_out_count = 9'd500;
    repeat (20) cyc();
    vectors++;
    if (wq.size() - n > 1) begin errors++; $display("FAIL fifo_500: got %0d writes want <=1", wq.size() - n); end
    n = wq.size();
    pipe_out_count = 9'd0;
    repeat (6) cyc();
    vectors++;
    if (wq.size() - n < 4) begin errors++; $display("FAIL fifo_resume: got %0d writes want >=4", wq.size() - n); end
    seq_ok = 1'b1;
    for (int i = 0; i < wq.size(); i++)
      if (wq[i] !== {32'(i + 1), 32'(i + 1)}) seq_ok = 1'b0;
    vectors++;
    if (!seq_ok) begin errors++; $display("FAIL fifo_seq: got gap/skip in %0d words want consecutive", wq.size()); end
    pulse_abort();
    repeat (2) cyc();
  endtask

  task automatic test_abort();
    clear_log();
    pulse_start(2'd0, 32'd0, 32'd0);
    repeat (5) cyc();
    abort = 1'b1;
    start = 1'b1;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    clear_log();
    repeat (10) cyc();
    vectors += 3;
    if (wq.size() != 0) begin errors++; $display("FAIL abort_writes: got %0d want 0", wq.size()); end
    if (busy_s !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_s); end
    if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
    clear_log();
    pulse_start(2'd0, 32'd3, 32'd0);
    repeat (10) cyc();
    vectors += 3;
    if (wq.size() != 3) begin
      errors++; $display("FAIL restart_count: got %0d want 3", wq.size());
    end else if (wq[0] !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL restart_seed: got %h want %h", wq[0], {32'd1, 32'd1});
    end
    if (done_cnt != 1) begin errors++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
    if (wq.size() == 3 && wq[2] !== {32'd3, 32'd3}) begin
      errors++; $display("FAIL restart_w2: got %h want %h", wq[2], {32'd3, 32'd3});
    end
  endtask

  task automatic test_async_reset();
    load_throttle(32'h0000_0003);
    pulse_start(2'd0, 32'd0, 32'd0);
    repeat (6) cyc();
    #2 reset = 1'b1;
    #1;
    vectors += 5;
    if (pipe_out_write !== 1'b0) begin errors++; $display("FAIL arst_write: got %b want 0", pipe_out_write); end
    if (pipe_out_data !== 64'd0) begin errors++; $display("FAIL arst_data: got %h want 0", pipe_out_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", done); end
    if (dut.throttle !== 32'hFFFF_FFFF) begin errors++; $display("FAIL arst_throttle: got %h want ffffffff", dut.throttle); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

`ifdef PIPE_OUT_GEN_ERRINJ_EN
  task automatic test_errinj();
    logic [63:0] exp_v;
    load_throttle(32'hFFFF_FFFF);
    clear_log();
    errinj_arm = 1'b1;
    errinj_idx = 32'd2;
    pulse_start(2'd3, 32'd5, 32'hA5A5_A5A5);
    errinj_arm = 1'b0;
    repeat (10) cyc();
    vectors++;
    if (wq.size() != 5) begin errors++; $display("FAIL inj_count: got %0d want 5", wq.size()); end
    for (int i = 0; i < wq.size(); i++) begin
      exp_v = (i == 2) ? 64'hA5A5_A5A5_A5A5_A5A4 : 64'hA5A5_A5A5_A5A5_A5A5;
      vectors++;
      if (wq[i] !== exp_v) begin errors++; $display("FAIL inj_w%0d: got %h want %h", i, wq[i], exp_v); end
    end
  endtask
`endif

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    mode           = 2'd0;
    xfer_len       = 32'd0;
    pattern        = 32'd0;
    throttle_set   = 1'b0;
    throttle_val   = 32'd0;
    pipe_out_count = 9'd0;
`ifdef PIPE_OUT_GEN_ERRINJ_EN
    errinj_arm     = 1'b0;
    errinj_idx     = 32'd0;
`endif
    done_cnt       = 0;
    busy_s         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_lfsr();
    test_walk();
    test_throttle();
    test_fifo_limit();
    test_abort();
    test_async_reset();
`ifdef PIPE_OUT_GEN_ERRINJ_EN
    test_errinj();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
